// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor (a - b, LSB first) behind ready/valid handshakes.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
    parameter int unsigned SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output logic            ovf,
`endif
    output logic [SIZE:0]   diff
);

    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SIZE-1:0] a_sh;
    logic [SIZE-1:0] b_sh;
    logic [SIZE-1:0] res;
    logic [SIZE-1:0] res_nxt;
    logic            borrow;
    logic            borrow_nxt;
    logic            d;
    logic [CNT_W-1:0] cnt;
    logic            last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic            a_msb;
    logic            b_msb;
`endif

    assign in_ready = (state == IDLE);

    // One full-subtractor slice; the new bit enters the result from the MSB side.
    always_comb begin
        d          = a_sh[0] ^ b_sh[0] ^ borrow;
        borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        res_nxt    = SIZE'({d, res} >> 1);
        last_bit   = (cnt == CNT_W'(SIZE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, bit-serial shifting and result/valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            out_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[SIZE-1];
                        b_msb  <= b[SIZE-1];
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_nxt;
                    res    <= res_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff      <= {borrow_nxt, res_nxt};
                        out_valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= (a_msb != b_msb) & (res_nxt[SIZE-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (SIZE=8): directed vector table plus
// backpressure, mid-run reset and back-to-back sequences.
module tb_serial_sub;

    localparam int unsigned SIZE = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE:0]   diff;
`ifdef SERIAL_SUB_OVF_EN
    logic            ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    serial_sub #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf),
`endif
        .diff      (diff)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE:0]   d;
        logic            ovf;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_in_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({name, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    // Issue one operation; out_ready must already be set by the caller.
    task automatic do_op(input string name, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                         input logic [SIZE:0] exp_d, input logic exp_ovf);
        int lat;
        int ir_bad;
        wait_in_ready(name);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        lat = 0;
        ir_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(SIZE));
        chk({name, "_diff"}, 64'(diff), 64'(exp_d));
        chk({name, "_in_ready_busy"}, 64'(ir_bad + int'(in_ready)), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected X in ovf expectation");
`endif
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({name, "_post_hs_in_ready"}, 64'(in_ready), 64'd1);
            chk({name, "_post_hs_out_valid"}, 64'(out_valid), 64'd0);
            chk({name, "_post_hs_diff_hold"}, 64'(diff), 64'(exp_d));
        end
    endtask

    initial begin
        logic [SIZE:0] held;
        int bad;
        logic [SIZE-1:0] pa [4];
        logic [SIZE-1:0] pb [4];
        logic [SIZE:0]   pd [4];
        int acc_cyc [4];
        int idx_acc;
        int idx_res;
        bit pending;

        vecs[0]  = '{8'd200,  8'd55,   9'h091, 1'b0};
        vecs[1]  = '{8'd5,    8'd10,   9'h1FB, 1'b0};
        vecs[2]  = '{8'd0,    8'd255,  9'h101, 1'b0};
        vecs[3]  = '{8'd0,    8'd0,    9'h000, 1'b0};
        vecs[4]  = '{8'd255,  8'd255,  9'h000, 1'b0};
        vecs[5]  = '{8'h80,   8'h01,   9'h07F, 1'b1};
        vecs[6]  = '{8'h7F,   8'hFF,   9'h180, 1'b1};
        vecs[7]  = '{8'h10,   8'h05,   9'h00B, 1'b0};
        vecs[8]  = '{8'd1,    8'd2,    9'h1FF, 1'b0};
        vecs[9]  = '{8'd128,  8'd127,  9'h001, 1'b1};
        vecs[10] = '{8'd3,    8'd1,    9'h002, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_diff", 64'(diff), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ovf);
        end

        // Backpressure: DONE held while out_ready is low, in_valid pulses ignored.
        out_ready = 1'b0;
        do_op("bp", 8'd50, 8'd20, 9'h01E, 1'b0);
        held = diff;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 8'hAA;
            b = 8'h11;
            if (!out_valid || diff !== held || in_ready) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        chk("bp_diff_held", 64'(diff), 64'h01E);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of RUN discards the partial result.
        wait_in_ready("rst_mid");
        in_valid = 1'b1;
        a = 8'd100;
        b = 8'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_diff", 64'(diff), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("rst_mid_no_valid", 64'(bad), 64'd0);
        do_op("after_rst", 8'd3, 8'd1, 9'h002, 1'b0);

        // Back-to-back with in_valid held high.
        pa = '{8'd200, 8'd5,  8'h80, 8'd1};
        pb = '{8'd55,  8'd10, 8'h01, 8'd2};
        pd = '{9'h091, 9'h1FB, 9'h07F, 9'h1FF};
        idx_acc = 0;
        idx_res = 0;
        pending = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a = pa[0];
        b = pb[0];
        for (int n = 0; n < 200 && idx_res < 4; n++) begin
            if (n > 0) @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                idx_acc++;
                if (idx_acc < 4) begin
                    a = pa[idx_acc];
                    b = pb[idx_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk($sformatf("b2b_diff%0d", idx_res), 64'(diff), 64'(pd[idx_res]));
                idx_res++;
            end
            if (in_ready && in_valid && idx_acc < 4) begin
                acc_cyc[idx_acc] = cyc;
                pending = 1'b1;
            end
        end
        chk("b2b_results", 64'(idx_res), 64'd4);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("b2b_spacing%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(SIZE + 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
